// File: rtl/alu_op_sequencer.sv
// Control stage in front of the 16-bit ALU slice array: latches one operation,
// drives the decoded ALU controls for SETTLE_CYCLES cycles, then captures result and flags.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Opcode,
  input  logic [3:0]  ShAmt,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Result,
  output logic        FlagZ,
  output logic        FlagN,
  output logic        FlagC,
  output logic        FlagV,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic        CIn,
  output logic        SUB,
  output logic        ZeroA,
  output logic        FAOut,
  output logic        AND,
  output logic        OR,
  output logic        XOR,
  output logic        NOT,
  output logic        NAND,
  output logic        NOR,
  output logic        Sign,
  output logic        ShSignIn,
  output logic        Sh1,
  output logic        Sh2,
  output logic        Sh4,
  output logic        Sh8,
  output logic        ShB,
  output logic        ShL,
  output logic        ShR,
  output logic        ShOut,
  output logic        LLI,
  output logic        ALUEnable,
  input  logic [15:0] ALUOut,
  input  logic        CIn_Slice,
  input  logic        COut,
  input  logic        nZ,
  input  logic        Sum
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG,
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR,
    OP_LSL, OP_LSR, OP_ASR, OP_LUI, OP_LLI
  } opcode_e;

  state_e      state_q, state_d;
  opcode_e     opc_q, opc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sh_q, sh_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        c_q, c_d;
  logic        v_q, v_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_DRIVE;
          opc_d   = opcode_e'(Opcode);
          sh_d    = ShAmt;
          a_d     = OpA;
          b_d     = OpB;
          cnt_d   = CNT_LOAD;
          // ADC/SBC use the carry as it stands now, not whatever it becomes later.
          carry_d = c_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = ST_DONE;
          result_d = ALUOut;
          if (opc_q <= OP_NEG) begin
            z_d = ~nZ;
            n_d = Sum;
            c_d = COut;
            v_d = CIn_Slice ^ COut;
          end else if (opc_q <= OP_ASR) begin
            z_d = ~nZ;
            n_d = Sum;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand latches are reset along with the rest because A/B must read 0 after reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      opc_q    <= OP_ADD;
      cnt_q    <= '0;
      sh_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    ALUEnable = 1'b0;
    CIn       = 1'b0;
    SUB       = 1'b0;
    ZeroA     = 1'b0;
    FAOut     = 1'b0;
    AND       = 1'b0;
    OR        = 1'b0;
    XOR       = 1'b0;
    NOT       = 1'b0;
    NAND      = 1'b0;
    NOR       = 1'b0;
    Sign      = 1'b0;
    ShSignIn  = 1'b0;
    Sh1       = 1'b0;
    Sh2       = 1'b0;
    Sh4       = 1'b0;
    Sh8       = 1'b0;
    ShB       = 1'b0;
    ShL       = 1'b0;
    ShR       = 1'b0;
    ShOut     = 1'b0;
    LLI       = 1'b0;

    if (state_q == ST_DRIVE) begin
      ALUEnable = 1'b1;
      case (opc_q)
        OP_ADD:  FAOut = 1'b1;
        OP_ADC:  begin FAOut = 1'b1; CIn = carry_q; end
        OP_SUB:  begin FAOut = 1'b1; SUB = 1'b1; CIn = 1'b1; end
        OP_SBC:  begin FAOut = 1'b1; SUB = 1'b1; CIn = carry_q; end
        OP_NEG:  begin FAOut = 1'b1; SUB = 1'b1; ZeroA = 1'b1; CIn = 1'b1; end
        OP_AND:  AND  = 1'b1;
        OP_OR:   OR   = 1'b1;
        OP_XOR:  XOR  = 1'b1;
        OP_NOT:  NOT  = 1'b1;
        OP_NAND: NAND = 1'b1;
        OP_NOR:  NOR  = 1'b1;
        OP_LSL:  begin ShOut = 1'b1; ShL = 1'b1; {Sh8, Sh4, Sh2, Sh1} = sh_q; end
        OP_LSR:  begin ShOut = 1'b1; ShR = 1'b1; {Sh8, Sh4, Sh2, Sh1} = sh_q; end
        OP_ASR:  begin
          ShOut = 1'b1; ShR = 1'b1; ShSignIn = 1'b1;
          {Sh8, Sh4, Sh2, Sh1} = sh_q;
        end
        OP_LUI:  begin ShOut = 1'b1; ShB = 1'b1; ShL = 1'b1; Sh8 = 1'b1; end
        OP_LLI:  begin ShOut = 1'b1; LLI = 1'b1; end
        default: ALUEnable = 1'b1;
      endcase
    end
  end

  assign Busy   = (state_q == ST_DRIVE);
  assign Done   = (state_q == ST_DONE);
  assign Result = result_q;
  assign FlagZ  = z_q;
  assign FlagN  = n_q;
  assign FlagC  = c_q;
  assign FlagV  = v_q;
  assign A      = a_q;
  assign B      = b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) each closed around a small ALU model,
// directed operations with hand-computed results checked by a queue-based scoreboard.
module tb_alu_op_sequencer;

  localparam int I_LLI = 0, I_SHOUT = 1, I_SHR = 2, I_SHL = 3, I_SHB = 4, I_SH8 = 5,
                 I_SH4 = 6, I_SH2 = 7, I_SH1 = 8, I_SHSIGN = 9, I_SIGN = 10, I_NOR = 11,
                 I_NAND = 12, I_NOT = 13, I_XOR = 14, I_OR = 15, I_AND = 16, I_FAOUT = 17,
                 I_ZEROA = 18, I_SUB = 19, I_CIN = 20;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;  // {Z, N, C, V}
  } exp_t;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  // Instance a: SETTLE_CYCLES = 1
  logic        rst_a, start_a;
  logic [3:0]  opc_a, sh_a;
  logic [15:0] opa_a, opb_a;
  wire         busy_a, done_a, en_a;
  wire  [15:0] res_a, abus_a, bbus_a;
  wire  [3:0]  flags_a;
  wire  [20:0] ctl_a;
  logic [15:0] aluout_a;
  logic        cslice_a, cout_a, nz_a, sum_a;

  // Instance b: SETTLE_CYCLES = 3
  logic        rst_b, start_b;
  logic [3:0]  opc_b, sh_b;
  logic [15:0] opa_b, opb_b;
  wire         busy_b, done_b, en_b;
  wire  [15:0] res_b, abus_b, bbus_b;
  wire  [3:0]  flags_b;
  wire  [20:0] ctl_b;
  logic [15:0] aluout_b;
  logic        cslice_b, cout_b, nz_b, sum_b;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut_a (
    .Clock(clk), .Reset(rst_a), .Start(start_a), .Opcode(opc_a), .ShAmt(sh_a),
    .OpA(opa_a), .OpB(opb_a), .Busy(busy_a), .Done(done_a), .Result(res_a),
    .FlagZ(flags_a[3]), .FlagN(flags_a[2]), .FlagC(flags_a[1]), .FlagV(flags_a[0]),
    .A(abus_a), .B(bbus_a),
    .CIn(ctl_a[I_CIN]), .SUB(ctl_a[I_SUB]), .ZeroA(ctl_a[I_ZEROA]), .FAOut(ctl_a[I_FAOUT]),
    .AND(ctl_a[I_AND]), .OR(ctl_a[I_OR]), .XOR(ctl_a[I_XOR]), .NOT(ctl_a[I_NOT]),
    .NAND(ctl_a[I_NAND]), .NOR(ctl_a[I_NOR]), .Sign(ctl_a[I_SIGN]), .ShSignIn(ctl_a[I_SHSIGN]),
    .Sh1(ctl_a[I_SH1]), .Sh2(ctl_a[I_SH2]), .Sh4(ctl_a[I_SH4]), .Sh8(ctl_a[I_SH8]),
    .ShB(ctl_a[I_SHB]), .ShL(ctl_a[I_SHL]), .ShR(ctl_a[I_SHR]), .ShOut(ctl_a[I_SHOUT]),
    .LLI(ctl_a[I_LLI]), .ALUEnable(en_a), .ALUOut(aluout_a),
    .CIn_Slice(cslice_a), .COut(cout_a), .nZ(nz_a), .Sum(sum_a)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) u_dut_b (
    .Clock(clk), .Reset(rst_b), .Start(start_b), .Opcode(opc_b), .ShAmt(sh_b),
    .OpA(opa_b), .OpB(opb_b), .Busy(busy_b), .Done(done_b), .Result(res_b),
    .FlagZ(flags_b[3]), .FlagN(flags_b[2]), .FlagC(flags_b[1]), .FlagV(flags_b[0]),
    .A(abus_b), .B(bbus_b),
    .CIn(ctl_b[I_CIN]), .SUB(ctl_b[I_SUB]), .ZeroA(ctl_b[I_ZEROA]), .FAOut(ctl_b[I_FAOUT]),
    .AND(ctl_b[I_AND]), .OR(ctl_b[I_OR]), .XOR(ctl_b[I_XOR]), .NOT(ctl_b[I_NOT]),
    .NAND(ctl_b[I_NAND]), .NOR(ctl_b[I_NOR]), .Sign(ctl_b[I_SIGN]), .ShSignIn(ctl_b[I_SHSIGN]),
    .Sh1(ctl_b[I_SH1]), .Sh2(ctl_b[I_SH2]), .Sh4(ctl_b[I_SH4]), .Sh8(ctl_b[I_SH8]),
    .ShB(ctl_b[I_SHB]), .ShL(ctl_b[I_SHL]), .ShR(ctl_b[I_SHR]), .ShOut(ctl_b[I_SHOUT]),
    .LLI(ctl_b[I_LLI]), .ALUEnable(en_b), .ALUOut(aluout_b),
    .CIn_Slice(cslice_b), .COut(cout_b), .nZ(nz_b), .Sum(sum_b)
  );

  // Behavioural ALU slice array; returns {CIn_Slice, COut, nZ, Sum, ALUOut}.
  function automatic logic [19:0] alu_fn(input logic [20:0] c, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] ae, be, src, o, s15;
    logic [16:0] s17;
    logic [3:0]  amt;
    logic        cs, co;
    o  = '0;
    cs = 1'b0;
    co = 1'b0;
    if (c[I_FAOUT]) begin
      ae  = c[I_ZEROA] ? 16'h0000 : a;
      be  = c[I_SUB] ? ~b : b;
      s17 = {1'b0, ae} + {1'b0, be} + {16'd0, c[I_CIN]};
      s15 = {1'b0, ae[14:0]} + {1'b0, be[14:0]} + {15'd0, c[I_CIN]};
      o   = s17[15:0];
      co  = s17[16];
      cs  = s15[15];
    end
    if (c[I_AND])  o = o | (a & b);
    if (c[I_OR])   o = o | (a | b);
    if (c[I_XOR])  o = o | (a ^ b);
    if (c[I_NOT])  o = o | ~a;
    if (c[I_NAND]) o = o | ~(a & b);
    if (c[I_NOR])  o = o | ~(a | b);
    if (c[I_SHOUT]) begin
      src = c[I_SHB] ? b : a;
      amt = {c[I_SH8], c[I_SH4], c[I_SH2], c[I_SH1]};
      if (c[I_SHL]) o = o | (src << amt);
      if (c[I_SHR]) o = o | (c[I_SHSIGN] ? 16'($signed(src) >>> amt) : (src >> amt));
    end
    if (c[I_LLI]) o = o | {a[15:8], b[7:0]};
    return {cs, co, |o, o[15], o};
  endfunction

  always_comb {cslice_a, cout_a, nz_a, sum_a, aluout_a} = alu_fn(ctl_a, abus_a, bbus_a);
  always_comb {cslice_b, cout_b, nz_b, sum_b, aluout_b} = alu_fn(ctl_b, abus_b, bbus_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected entry whenever Done is presented.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_done: Done with empty scoreboard (t=%0t)", $time);
      end else begin
        e_a = q_a.pop_front();
        check("a_result", res_a, e_a.res);
        check("a_flags", flags_a, e_a.flags);
        check("a_ctl_idle", ctl_a, 0);
        check("a_en_idle", en_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_done: Done with empty scoreboard (t=%0t)", $time);
      end else begin
        e_b = q_b.pop_front();
        check("b_result", res_b, e_b.res);
        check("b_flags", flags_b, e_b.flags);
      end
    end
  end

  task automatic do_op_a(input logic [3:0] op, input logic [3:0] sh, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    int lat, busy_cnt;
    bit seen;
    q_a.push_back({er, ef});
    @(negedge clk);
    opc_a = op; sh_a = sh; opa_a = a; opb_a = b; start_a = 1'b1;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      start_a = 1'b0;
      if (done_a === 1'b1) seen = 1'b1;
      else if (busy_a === 1'b1) begin
        busy_cnt++;
        check("a_en_drive", en_a, 1);
        check("a_sign_low", ctl_a[I_SIGN], 0);
      end
    end
    check("a_latency", lat, 2);
    check("a_busy_cycles", busy_cnt, 1);
    check("a_bus_a_hold", abus_a, a);
    check("a_bus_b_hold", bbus_a, b);
    @(negedge clk);
    check("a_done_one_cycle", done_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    rst_a = 1'b1; start_a = 1'b1; opc_a = 4'd0; sh_a = 4'd0; opa_a = 16'h1111; opb_a = 16'h2222;
    rst_b = 1'b1; start_b = 1'b0; opc_b = 4'd0; sh_b = 4'd0; opa_b = 16'h0000; opb_b = 16'h0000;
    repeat (3) @(negedge clk);
    check("a_reset_beats_start", busy_a, 0);
    rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("a_reset_result", res_a, 0);
    check("a_reset_flags", flags_a, 0);
    check("a_reset_busy", busy_a, 0);
    check("a_reset_done", done_a, 0);
    check("a_reset_abus", abus_a, 0);
    check("a_reset_bbus", bbus_a, 0);
    check("a_reset_ctl", {en_a, ctl_a}, 0);

    // Instance a: functional vectors, flags {Z,N,C,V} carried through by hand.
    do_op_a(4'd0,  4'd0,  16'd16328, 16'd9000, 16'd25328, 4'b0000); // ADD
    do_op_a(4'd2,  4'd0,  16'd16328, 16'd9000, 16'd7328,  4'b0010); // SUB
    do_op_a(4'd4,  4'd0,  16'd16328, 16'd9000, 16'd56536, 4'b0100); // NEG
    do_op_a(4'd0,  4'd0,  16'hFFFF,  16'h0001, 16'h0000,  4'b1010); // ADD wrap
    do_op_a(4'd1,  4'd0,  16'h0000,  16'h0000, 16'h0001,  4'b0000); // ADC with C=1
    do_op_a(4'd0,  4'd0,  16'h7FFF,  16'h0001, 16'h8000,  4'b0101); // ADD overflow
    do_op_a(4'd13, 4'd15, 16'h8000,  16'h0000, 16'hFFFF,  4'b0101); // ASR
    do_op_a(4'd11, 4'd4,  16'h3F48,  16'h0000, 16'hF480,  4'b0101); // LSL keeps C,V
    do_op_a(4'd2,  4'd0,  16'h0003,  16'h0005, 16'hFFFE,  4'b0100); // SUB borrow
    do_op_a(4'd3,  4'd0,  16'h000A,  16'h0003, 16'h0006,  4'b0010); // SBC with C=0
    do_op_a(4'd14, 4'd3,  16'h1234,  16'h0008, 16'h0800,  4'b0010); // LUI
    do_op_a(4'd15, 4'd0,  16'h3F48,  16'd67,   16'h3F43,  4'b0010); // LLI
    do_op_a(4'd5,  4'd0,  16'h0F0F,  16'h00F0, 16'h0000,  4'b1010); // AND -> zero
    do_op_a(4'd10, 4'd0,  16'h0000,  16'h0F00, 16'hF0FF,  4'b0110); // NOR
    do_op_a(4'd12, 4'd15, 16'h8000,  16'h0000, 16'h0001,  4'b0010); // LSR

    // Instance b: Start held high across three back-to-back XOR operations.
    repeat (3) q_b.push_back({16'h0FF0, 4'b0000});
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      check("b_hold_busy", busy_b, (i > 0 && (i % 4) != 0) ? 1 : 0);
      check("b_hold_done", done_b, (i > 0 && (i % 4) == 0) ? 1 : 0);
      if (i == 0) begin
        opc_b = 4'd7; opa_b = 16'h00FF; opb_b = 16'h0F0F;
      end
      start_b = (i < 12);
    end

    // Instance b: a Start pulse with different operands during DRIVE must be ignored.
    q_b.push_back({16'h1234, 4'b0000});
    @(negedge clk);
    opc_b = 4'd5; opa_b = 16'hFFFF; opb_b = 16'h1234; start_b = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done_b === 1'b1) seen = 1'b1;
      start_b = (lat == 2);
      if (lat == 2) begin
        opc_b = 4'd0; opa_b = 16'h0000; opb_b = 16'h0000;
      end
    end
    start_b = 1'b0;
    check("b_latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_no_queued_start", busy_b, 0);
    end

    // Instance b: reset in the middle of DRIVE aborts the operation.
    @(negedge clk);
    opc_b = 4'd0; opa_b = 16'h0001; opb_b = 16'h0001; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_abort_in_drive", busy_b, 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_abort_busy", busy_b, 0);
    check("b_abort_done", done_b, 0);
    check("b_abort_result", res_b, 0);
    check("b_abort_flags", flags_b, 0);
    check("b_abort_abus", abus_b, 0);
    check("b_abort_bbus", bbus_b, 0);
    check("b_abort_ctl", {en_b, ctl_b}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_abort_no_done", done_b, 0);
      check("b_abort_result_zero", res_b, 0);
    end

    repeat (3) @(negedge clk);
    check("a_scoreboard_drained", q_a.size(), 0);
    check("b_scoreboard_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream control stage for the 16-bit ALU slice array. It accepts one ALU operation request at a time as an opcode, shift amount and two operands, and drives the ALU's one-hot control lines and operand buses for a programmable settle interval. It then captures ALUOut into a result register and the ALU flag outputs into a Z/N/C/V status register. It sits between instruction decode and the ALU datapath.

Parameters:
SETTLE_CYCLES, 1, number of DRIVE cycles before capture; legal range 1..15, 0 illegal.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; accepted when Busy=0
Opcode  input  4  operation select (see Behaviour)
ShAmt  input  4  shift distance 0..15; bit0..3 map to Sh1/Sh2/Sh4/Sh8
OpA, OpB  input  16  operands, sampled on accept
Busy  output  1  high in DRIVE state
Done  output  1  one-cycle pulse, Result/flags just updated
Result  output  16  captured ALUOut
FlagZ, FlagN, FlagC, FlagV  output  1  status register
A, B  output  16  latched operands to ALU
CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR, Sign, ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut, LLI  output  1 each  ALU controls
ALUEnable  output  1  ALU output enable
ALUOut  input  16  ALU result
CIn_Slice, COut, nZ, Sum  input  1  ALU flags (carry into MSB, carry out, not-zero, MSB)

Behaviour:
- Single clock (Clock); Reset is synchronous and active-high. Reset forces state IDLE. Result, all flags, Busy, Done, A, B, all control outputs and ALUEnable are 0. Reset beats Start.
- States: IDLE, DRIVE, DONE. Done=1 only in DONE; Busy=1 only in DRIVE.
- IDLE or DONE with Start=1: latch Opcode/ShAmt/OpA/OpB, load counter with SETTLE_CYCLES-1, go to DRIVE. DONE with Start=0 goes to IDLE. Start during DRIVE is ignored; no queueing.
- DRIVE: ALUEnable=1 and controls are decoded from the latched opcode. If counter≠0, decrement. If counter=0, capture Result<=ALUOut, update flags, go to DONE.
- Latency: Start sampled at edge 0 gives Done high during cycle SETTLE_CYCLES+1. Back-to-back Start in DONE gives one operation per SETTLE_CYCLES+1 cycles.
- Outside DRIVE, all controls and ALUEnable are 0. A and B hold the last latched operands.
- Opcode decode (controls not listed are 0):
  - 0 ADD: FAOut.
  - 1 ADC: FAOut, CIn=FlagC.
  - 2 SUB: FAOut, SUB, CIn=1.
  - 3 SBC: FAOut, SUB, CIn=FlagC.
  - 4 NEG: FAOut, SUB, ZeroA, CIn=1, giving 0-B.
  - 5 AND, 6 OR, 7 XOR, 8 NOT, 9 NAND, 10 NOR: the matching single control.
  - 11 LSL: ShOut, ShL, Sh* from ShAmt.
  - 12 LSR: ShOut, ShR, Sh*.
  - 13 ASR: ShOut, ShR, ShSignIn, Sh*.
  - 14 LUI: ShOut, ShB, ShL, Sh8 (ShAmt ignored).
  - 15 LLI: ShOut, LLI.
- Flag update at capture:
  - Opcodes 0-4: Z=~nZ, N=Sum, C=COut, V=CIn_Slice^COut.
  - Opcodes 5-13: Z, N updated; C, V retained.
  - Opcodes 14-15: no flag change.
- The carry for ADC/SBC is FlagC as it stood at accept time; it is frozen for the whole operation.
- Reset during DRIVE aborts the operation: no Result or flag update, and no Done.
- Sign output is held at 0 in this revision.

Test Plan:
- SETTLE_CYCLES=1, ADD, OpA=16328, OpB=9000 → Done in cycle 2 after accept, Result=25328, Z=0 N=0 C=0 V=0; Busy high exactly 1 cycle.
- SUB 16328-9000 → Result=7328, C=1. Then NEG OpB=9000 → Result=56536, N=1, C=0.
- ADD 0xFFFF+0x0001 → Result=0, Z=1, C=1, V=0. Then ADC 0+0 → Result=1, Z=0, C=0. Then ADD 0x7FFF+0x0001 → Result=0x8000, N=1, V=1.
- ASR OpA=0x8000 ShAmt=15 → 0xFFFF. LSL OpA=0x3F48 ShAmt=4 → 0xF480 with C,V unchanged. LUI OpB=8 → 0x0800. LLI OpA=0x3F48 OpB=67 → 0x3F43 with flags unchanged.
- SETTLE_CYCLES=3: Start held high continuously → Busy 3 cycles then Done 1 cycle, repeating; Start pulses during DRIVE are ignored.
- Reset asserted mid-DRIVE → next cycle all outputs 0 and state IDLE; Result stays 0 and Done never pulses for the aborted operation.
